// File: rtl/inv_exp_ctrl.sv
// ============================================================================
// inv_exp_ctrl : sequencer for masked GF(2^8) inversion x^254 on (8+D)-bit words
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module inv_exp_ctrl #(
  parameter int D = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [8+D-1:0] x_in_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [8+D-1:0] y_out_o,
  input  logic           rnd_valid_i,
  input  logic [D-1:0]   rnd_i,
  output logic           rnd_ready_o,
  output logic [8+D-1:0] sq_in_o,
  output logic [D-1:0]   sq_r_o,
  input  logic [8+D-1:0] sq_out_i,
  output logic [8+D-1:0] mul_a_o,
  output logic [8+D-1:0] mul_b_o,
  output logic [D-1:0]   mul_r_o,
  input  logic [8+D-1:0] mul_out_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } fsm_e;

  fsm_e           state_q, state_d;
  logic [3:0]     step_q, step_d;
  logic [8+D-1:0] x_q, x_d;
  logic [8+D-1:0] t_q, t_d;
  logic [8+D-1:0] r2_q, r2_d;
  logic [8+D-1:0] r3_q, r3_d;
  logic [8+D-1:0] r12_q, r12_d;
  logic [8+D-1:0] y_q, y_d;

  logic           is_mul;
  logic [8+D-1:0] op_res;

  // Multiplier steps of the chain and their second operand; all others square T.
  always_comb begin
    is_mul  = 1'b0;
    mul_b_o = x_q;
    case (step_q)
      4'd1:    begin is_mul = 1'b1; mul_b_o = x_q;   end
      4'd4:    begin is_mul = 1'b1; mul_b_o = r3_q;  end
      4'd9:    begin is_mul = 1'b1; mul_b_o = r12_q; end
      4'd10:   begin is_mul = 1'b1; mul_b_o = r2_q;  end
      default: begin is_mul = 1'b0; mul_b_o = x_q;   end
    endcase
  end

  assign op_res      = is_mul ? mul_out_i : sq_out_i;
  assign sq_in_o     = t_q;
  assign mul_a_o     = t_q;
  assign sq_r_o      = rnd_i;
  assign mul_r_o     = rnd_i;
  assign busy_o      = (state_q == S_RUN) || (state_q == S_FINISH);
  assign rnd_ready_o = (state_q == S_RUN);
  assign done_o      = (state_q == S_FINISH);
  assign y_out_o     = y_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    x_d     = x_q;
    t_d     = t_q;
    r2_d    = r2_q;
    r3_d    = r3_q;
    r12_d   = r12_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          x_d     = x_in_i;
          t_d     = x_in_i;
          step_d  = 4'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A step advances only when a refresh word is handed over.
        if (rnd_valid_i) begin
          t_d = op_res;
          case (step_q)
            4'd0:    r2_d  = sq_out_i;
            4'd1:    r3_d  = mul_out_i;
            4'd3:    r12_d = sq_out_i;
            default: ;
          endcase
          if (step_q == 4'd10) begin
            y_d     = op_res;
            state_d = S_FINISH;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= 4'd0;
      x_q     <= '0;
      t_q     <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      r12_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      x_q     <= x_d;
      t_q     <= t_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      r12_q   <= r12_d;
      y_q     <= y_d;
    end
  end

endmodule

`default_nettype wire
